// File: rtl/wb_syscall_console_if.sv
// Writeback syscall console bus: pipeline syscall operands, data-memory read port,
// console character stream and sticky status flags.
interface wb_syscall_console_if #(
    parameter int DATA_W = 32
);
    logic              syscall_in;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              stall_out;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        char_out;
    logic              char_valid;
    logic              char_ready;
    logic              halt;
    logic              truncated;

    modport master (
        output syscall_in, v0, a0, mem_rdata, char_ready,
        input  stall_out, mem_req, mem_addr, char_out, char_valid, halt, truncated
    );

    modport slave (
        input  syscall_in, v0, a0, mem_rdata, char_ready,
        output stall_out, mem_req, mem_addr, char_out, char_valid, halt, truncated
    );
endinterface

// File: rtl/wb_syscall_console.sv
// Syscall service unit: prints string/hex/char over a valid/ready port, latches exit.
// 3 cycles per string char (+2 for NUL), 1 per hex digit/char; holds char_out while char_ready=0.
module wb_syscall_console #(
    parameter int DATA_W         = 32,
    parameter int MAX_STR_LEN    = 256,
    parameter int SVC_PRINT_INT  = 1,
    parameter int SVC_PRINT_STR  = 4,
    parameter int SVC_EXIT       = 10,
    parameter int SVC_PRINT_CHAR = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_syscall_console_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);
    localparam int IDX_W = (DATA_W / 4 > 1) ? $clog2(DATA_W / 4) : 1;

    typedef enum logic [2:0] {
        IDLE, STR_REQ, STR_WAIT, STR_EMIT, HEX_EMIT, CHR_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        char_out_q, char_out_d;
    logic              char_vld_q, char_vld_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              halt_q, halt_d;
    logic              trunc_q, trunc_d;

    logic              take;
    logic              svc_str, svc_int, svc_chr, svc_exit;
    logic [DATA_W-1:0] rd_shift;
    logic [7:0]        rd_byte;

    function automatic logic [7:0] hex_char(input logic [DATA_W-1:0] v,
                                            input logic [IDX_W-1:0]  i);
        logic [DATA_W-1:0] s;
        logic [3:0]        n;
        s = v >> {i, 2'b00};
        n = s[3:0];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign take     = (state_q == IDLE) && bus.syscall_in && !halt_q;
    assign svc_str  = (bus.v0 == DATA_W'(SVC_PRINT_STR));
    assign svc_int  = (bus.v0 == DATA_W'(SVC_PRINT_INT));
    assign svc_chr  = (bus.v0 == DATA_W'(SVC_PRINT_CHAR));
    assign svc_exit = (bus.v0 == DATA_W'(SVC_EXIT));

    // Big-endian lane pick: shifting the wanted byte to the top avoids a per-lane mux.
    assign rd_shift = bus.mem_rdata << {ptr_q[1:0], 3'b000};
    assign rd_byte  = rd_shift[DATA_W-1 -: 8];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        char_out_d = char_out_q;
        char_vld_d = char_vld_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        halt_d     = halt_q;
        trunc_d    = trunc_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (svc_str) begin
                        ptr_d      = bus.a0;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.a0[DATA_W-1:2], 2'b00};
                        state_d    = STR_REQ;
                    end else if (svc_int) begin
                        val_d      = bus.a0;
                        idx_d      = IDX_W'(DATA_W / 4 - 1);
                        char_out_d = hex_char(bus.a0, IDX_W'(DATA_W / 4 - 1));
                        char_vld_d = 1'b1;
                        state_d    = HEX_EMIT;
                    end else if (svc_chr) begin
                        char_out_d = bus.a0[7:0];
                        char_vld_d = 1'b1;
                        state_d    = CHR_EMIT;
                    end else if (svc_exit) begin
                        halt_d = 1'b1;
                    end
                end
            end
            STR_REQ: state_d = STR_WAIT;
            STR_WAIT: begin
                if (rd_byte == 8'h00) begin
                    state_d = IDLE;
                end else begin
                    char_out_d = rd_byte;
                    char_vld_d = 1'b1;
                    state_d    = STR_EMIT;
                end
            end
            STR_EMIT: begin
                if (bus.char_ready) begin
                    char_vld_d = 1'b0;
                    ptr_d      = ptr_q + DATA_W'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MAX_STR_LEN)) begin
                        trunc_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {ptr_d[DATA_W-1:2], 2'b00};
                        state_d    = STR_REQ;
                    end
                end
            end
            HEX_EMIT: begin
                if (bus.char_ready) begin
                    if (idx_q == '0) begin
                        char_vld_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        idx_d      = idx_q - IDX_W'(1);
                        char_out_d = hex_char(val_q, idx_d);
                    end
                end
            end
            CHR_EMIT: begin
                if (bus.char_ready) begin
                    char_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            val_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            char_out_q <= '0;
            char_vld_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            halt_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            char_out_q <= char_out_d;
            char_vld_q <= char_vld_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            halt_q     <= halt_d;
            trunc_q    <= trunc_d;
        end
    end

    // Stall is combinational in IDLE so the syscall stays parked in WB while service starts.
    assign bus.stall_out  = (state_q != IDLE) || (take && (svc_str || svc_int || svc_chr));
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_vld_q;
    assign bus.halt       = halt_q;
    assign bus.truncated  = trunc_q;
endmodule

// File: tb/tb_wb_syscall_console.sv
// Directed bench for wb_syscall_console: per-cycle vector table plus hand sequences
// for truncation, exit/halt and mid-string reset.
module tb_wb_syscall_console;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        sc = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        rdy = 1'b1;
    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    wb_syscall_console_if #(.DATA_W(32)) ifa ();
    wb_syscall_console_if #(.DATA_W(32)) ifb ();

    wb_syscall_console u_dut (.clk(clk), .reset(reset), .bus(ifa.slave));
    wb_syscall_console #(.MAX_STR_LEN(4)) u_small (.clk(clk), .reset(reset), .bus(ifb.slave));

    assign ifa.syscall_in = sc & ~sel;
    assign ifb.syscall_in = sc & sel;
    assign ifa.v0 = v0;
    assign ifb.v0 = v0;
    assign ifa.a0 = a0;
    assign ifb.a0 = a0;
    assign ifa.char_ready = rdy;
    assign ifb.char_ready = rdy;

    always @(posedge clk) if (ifa.mem_req) ifa.mem_rdata <= mem[ifa.mem_addr[9:2]];
    always @(posedge clk) if (ifb.mem_req) ifb.mem_rdata <= mem[ifb.mem_addr[9:2]];

    logic        o_stall, o_vld, o_req, o_halt, o_trunc;
    logic [7:0]  o_chr;
    logic [31:0] o_addr;
    assign o_stall = sel ? ifb.stall_out  : ifa.stall_out;
    assign o_vld   = sel ? ifb.char_valid : ifa.char_valid;
    assign o_req   = sel ? ifb.mem_req    : ifa.mem_req;
    assign o_halt  = sel ? ifb.halt       : ifa.halt;
    assign o_trunc = sel ? ifb.truncated  : ifa.truncated;
    assign o_chr   = sel ? ifb.char_out   : ifa.char_out;
    assign o_addr  = sel ? ifb.mem_addr   : ifa.mem_addr;

    typedef struct {
        string       name;
        logic        sc;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        rdy;
        logic        e_stall;
        logic        e_vld;
        logic [7:0]  e_chr;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic s, input logic [31:0] v, input logic [31:0] a,
                       input logic r, input logic st, input logic vl, input logic [7:0] ch,
                       input logic rq, input logic [31:0] ad);
        vec_t e;
        e.name = name; e.sc = s; e.v0 = v; e.a0 = a; e.rdy = r;
        e.e_stall = st; e.e_vld = vl; e.e_chr = ch; e.e_req = rq; e.e_addr = ad;
        vecs.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic print_char_seq(input string tag, input logic [7:0] ch);
        sc = 1'b1; v0 = 32'd11; a0 = {24'h0, ch}; rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_stall0"}, {31'h0, o_stall}, 32'd1);
        chk({tag, "_vld0"}, {31'h0, o_vld}, 32'd0);
        next_cycle();
        sc = 1'b0;
        @(negedge clk);
        chk({tag, "_vld1"}, {31'h0, o_vld}, 32'd1);
        chk({tag, "_chr"}, {24'h0, o_chr}, {24'h0, ch});
        next_cycle();
        @(negedge clk);
        chk({tag, "_vld_end"}, {31'h0, o_vld}, 32'd0);
        chk({tag, "_stall_end"}, {31'h0, o_stall}, 32'd0);
    endtask

    initial begin
        string       hexs;
        logic [7:0]  got [$];
        logic        done;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h4869_0000;   // "Hi\0" at 0x100
        mem[8'h80] = 32'h1122_4142;   // 'A','B' at 0x202/0x203
        mem[8'h81] = 32'h00FF_FFFF;   // NUL at 0x204
        mem[8'hC0] = 32'h4142_4344;   // "ABCD"
        mem[8'hC1] = 32'h4546_4700;   // "EFG\0"

        // "Hi" from 0x100
        add("hi_trig", 1, 4, 32'h100, 1, 1, 0, 0,     0, 0);
        add("hi_req0", 0, 4, 32'h100, 1, 1, 0, 0,     1, 32'h100);
        add("hi_wt0",  0, 4, 32'h100, 1, 1, 0, 0,     0, 0);
        add("hi_em0",  0, 4, 32'h100, 1, 1, 1, 8'h48, 0, 0);
        add("hi_req1", 0, 4, 32'h100, 1, 1, 0, 0,     1, 32'h100);
        add("hi_wt1",  0, 4, 32'h100, 1, 1, 0, 0,     0, 0);
        add("hi_em1",  0, 4, 32'h100, 1, 1, 1, 8'h69, 0, 0);
        add("hi_req2", 0, 4, 32'h100, 1, 1, 0, 0,     1, 32'h100);
        add("hi_wt2",  0, 4, 32'h100, 1, 1, 0, 0,     0, 0);
        add("hi_done", 0, 4, 32'h100, 1, 0, 0, 0,     0, 0);
        // Unaligned start at 0x202, crossing into word 0x204
        add("ua_trig", 1, 4, 32'h202, 1, 1, 0, 0,     0, 0);
        add("ua_req0", 0, 4, 32'h202, 1, 1, 0, 0,     1, 32'h200);
        add("ua_wt0",  0, 4, 32'h202, 1, 1, 0, 0,     0, 0);
        add("ua_em0",  0, 4, 32'h202, 1, 1, 1, 8'h41, 0, 0);
        add("ua_req1", 0, 4, 32'h202, 1, 1, 0, 0,     1, 32'h200);
        add("ua_wt1",  0, 4, 32'h202, 1, 1, 0, 0,     0, 0);
        add("ua_em1",  0, 4, 32'h202, 1, 1, 1, 8'h42, 0, 0);
        add("ua_req2", 0, 4, 32'h202, 1, 1, 0, 0,     1, 32'h204);
        add("ua_wt2",  0, 4, 32'h202, 1, 1, 0, 0,     0, 0);
        add("ua_done", 0, 4, 32'h202, 1, 0, 0, 0,     0, 0);
        // Hex print with char_ready toggling 0/1: each digit is shown once stalled, once accepted
        add("hx_trig", 1, 1, 32'h00C0FFEE, 0, 1, 0, 0, 0, 0);
        hexs = "00C0FFEE";
        for (int d = 0; d < 8; d++) begin
            add("hx_hold", 0, 1, 32'h00C0FFEE, 0, 1, 1, byte'(hexs[d]), 0, 0);
            add("hx_take", 0, 1, 32'h00C0FFEE, 1, 1, 1, byte'(hexs[d]), 0, 0);
        end
        add("hx_done", 0, 1, 32'h00C0FFEE, 1, 0, 0, 0, 0, 0);

        // Reset values, both instances
        sc = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            chk("rst_stall", {31'h0, o_stall}, 0);
            chk("rst_vld",   {31'h0, o_vld},   0);
            chk("rst_req",   {31'h0, o_req},   0);
            chk("rst_halt",  {31'h0, o_halt},  0);
            chk("rst_trunc", {31'h0, o_trunc}, 0);
            chk("rst_chr",   {24'h0, o_chr},   0);
            chk("rst_addr",  o_addr,           0);
            next_cycle();
        end

        sel = 1'b0;
        foreach (vecs[k]) begin
            sc = vecs[k].sc; v0 = vecs[k].v0; a0 = vecs[k].a0; rdy = vecs[k].rdy;
            @(negedge clk);
            chk({vecs[k].name, "_stall"}, {31'h0, o_stall}, {31'h0, vecs[k].e_stall});
            chk({vecs[k].name, "_vld"},   {31'h0, o_vld},   {31'h0, vecs[k].e_vld});
            if (vecs[k].e_vld) chk({vecs[k].name, "_chr"}, {24'h0, o_chr}, {24'h0, vecs[k].e_chr});
            chk({vecs[k].name, "_req"},   {31'h0, o_req},   {31'h0, vecs[k].e_req});
            if (vecs[k].e_req) chk({vecs[k].name, "_addr"}, o_addr, vecs[k].e_addr);
            next_cycle();
        end
        sc = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("main_trunc_clear", {31'h0, o_trunc}, 0);
        next_cycle();

        // Truncation on the MAX_STR_LEN=4 instance: "ABCDEFG" -> "ABCD"
        sel = 1'b1; sc = 1'b1; v0 = 32'd4; a0 = 32'h300; rdy = 1'b1;
        next_cycle();
        sc = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!o_stall) done = 1'b1;
            else if (o_vld && rdy) got.push_back(o_chr);
            if (!done) next_cycle();
        end
        chk("trunc_finished", {31'h0, done}, 1);
        chk("trunc_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk("trunc_char", {24'h0, got[i]}, 32'h41 + i);
        chk("trunc_flag", {31'h0, o_trunc}, 1);
        next_cycle();
        print_char_seq("small_z", 8'h7A);
        next_cycle();

        // Exit: halt next cycle, no stall; later syscalls ignored; reset clears
        sel = 1'b0; sc = 1'b1; v0 = 32'd10; a0 = 32'h0;
        @(negedge clk);
        chk("exit_stall", {31'h0, o_stall}, 0);
        chk("exit_halt_pre", {31'h0, o_halt}, 0);
        next_cycle();
        sc = 1'b0;
        @(negedge clk);
        chk("exit_halt", {31'h0, o_halt}, 1);
        next_cycle();
        sc = 1'b1; v0 = 32'd11; a0 = 32'h41;
        @(negedge clk);
        chk("halted_stall", {31'h0, o_stall}, 0);
        next_cycle();
        sc = 1'b0;
        @(negedge clk);
        chk("halted_vld", {31'h0, o_vld}, 0);
        chk("halted_stall2", {31'h0, o_stall}, 0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("halt_cleared", {31'h0, o_halt}, 0);
        next_cycle();

        // Reset mid-string while the sink is stalled
        sc = 1'b1; v0 = 32'd4; a0 = 32'h100; rdy = 1'b0;
        next_cycle();
        sc = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("mid_vld", {31'h0, o_vld}, 1);
        chk("mid_chr", {24'h0, o_chr}, 32'h48);
        next_cycle();
        @(negedge clk);
        chk("mid_hold_vld", {31'h0, o_vld}, 1);
        chk("mid_hold_chr", {24'h0, o_chr}, 32'h48);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld",   {31'h0, o_vld},   0);
        chk("mid_rst_stall", {31'h0, o_stall}, 0);
        chk("mid_rst_req",   {31'h0, o_req},   0);
        next_cycle();
        print_char_seq("after_rst_q", 8'h51);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
